bcd_to_binary: RTL and testbench
================================

// Module: bcd_to_binary
// PURPOSE
//  Sequential reverse double-dabble: converts a packed BCD value of DECIMAL_DIGITS
//  digits into an unsigned binary integer. Inverse of double_dabble.
//  Feeds decimal-entered values (keypad/switch digits, stopwatch presets) back into
//  binary arithmetic. START/DONE handshake matches double_dabble.
// PARAMETERS
//  DECIMAL_DIGITS  8   number of BCD nibbles on BCD input
//  OUTPUT_WIDTH    32  width of BINARY result; also the number of shift iterations
// PORTS
//  clk      in   1                 rising-edge clock
//  resetn   in   1                 asynchronous, active-low reset
//  BCD      in   4*DECIMAL_DIGITS  packed BCD, digit 0 in [3:0]; sampled only on accepted START
//  START    in   1                 request conversion; honoured only while BUSY=0
//  BINARY   out  OUTPUT_WIDTH      result; held from DONE until next DONE
//  DONE     out  1                 one-cycle pulse: BINARY/ERROR valid
//  ERROR    out  1                 invalid digit (>9) or result overflow; valid with DONE, held
//  BUSY     out  1                 high from cycle after START accepted until DONE pulse
// BEHAVIOUR
//  Reset (async, resetn=0): state IDLE; BINARY=0, DONE=0, ERROR=0, BUSY=0; work regs and
//   iteration counter cleared. Reset mid-conversion aborts it with no DONE.
//  Working reg sr = {bcd_part[4*DECIMAL_DIGITS-1:0], bin_part[OUTPUT_WIDTH-1:0]}.
//  States:
//   IDLE:   DONE<=0. If START: sr<={BCD,0}, inv<=(any BCD nibble >4'd9), cnt<=0,
//           BUSY<=1, ->SHIFT. Else stay.
//   SHIFT:  sr<=correct(sr>>1), cnt<=cnt+1. correct(): each bcd_part nibble >=8 gets
//           3 subtracted (all nibbles in parallel, same cycle as shift); bin_part untouched.
//           After OUTPUT_WIDTH shifts (cnt==OUTPUT_WIDTH-1 on this edge) ->FINISH.
//   FINISH: err = inv | (bcd_part!=0) (residue = overflow). BINARY<=err?0:bin_part,
//           ERROR<=err, DONE<=1, BUSY<=0, ->IDLE.
//  Timing: START sampled at edge 0; shifts on edges 1..OUTPUT_WIDTH; FINISH at edge
//   OUTPUT_WIDTH+1; DONE high for exactly the cycle after that edge (latency OUTPUT_WIDTH+1).
//  START while BUSY=1: ignored, no queueing. START in the DONE cycle (state IDLE): accepted;
//   min period between STARTs = OUTPUT_WIDTH+2 cycles.
//  BCD may change freely after edge 0; only the captured copy is used.
//  Invalid digits: conversion still runs full length (fixed latency); BINARY forced to 0.
//  Overflow: value >= 2^OUTPUT_WIDTH leaves non-zero bcd_part -> ERROR=1, BINARY=0.
//  Zero input: BINARY=0, ERROR=0. Counter width = clog2(OUTPUT_WIDTH)+1; no wrap possible.
//  BINARY/ERROR change only at FINISH edge or reset.
// TESTING
//  Defaults, BCD=32'h12345678, START 1 cycle -> DONE 33 cycles later, BINARY=32'h00BC614E, ERROR=0.
//  BCD=32'h99999999 -> BINARY=32'h05F5E0FF, ERROR=0; BCD=0 -> BINARY=0, ERROR=0.
//  BCD=32'h000000A0 -> DONE at same latency, ERROR=1, BINARY=0; next START with 32'h00000042
//   -> BINARY=32'h2A, ERROR=0 (error not sticky).
//  DECIMAL_DIGITS=4, OUTPUT_WIDTH=8: 16'h0255 -> 8'hFF, ERROR=0; 16'h0256 -> ERROR=1, BINARY=0.
//  START pulsed at cycles +5 and +20 of a conversion -> ignored, exactly one DONE; START held
//   high continuously -> back-to-back DONEs every 34 cycles; BCD changed after edge 0 -> no effect.
//  resetn low at shift 10 -> BUSY/DONE/ERROR/BINARY=0 immediately (async), no DONE; new START
//   after release converts correctly.

Source files
------------

// File: rtl/bcd_to_binary.sv
// Sequential reverse double-dabble: packed BCD in, unsigned binary out.
// One result bit per cycle from a right-shifting {bcd, bin} register with -3 digit correction.
module bcd_to_binary #(
    parameter int unsigned DECIMAL_DIGITS = 8,
    parameter int unsigned OUTPUT_WIDTH   = 32
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [4*DECIMAL_DIGITS-1:0] BCD,
    input  logic                        START,
    output logic [OUTPUT_WIDTH-1:0]     BINARY,
    output logic                        DONE,
    output logic                        ERROR,
    output logic                        BUSY
);

    localparam int unsigned BCD_W = 4 * DECIMAL_DIGITS;
    localparam int unsigned SR_W  = BCD_W + OUTPUT_WIDTH;
    localparam int unsigned CNT_W = $clog2(OUTPUT_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUTPUT_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t                    state, state_n;
    logic [SR_W-1:0]           sr, sr_n, sr_shift;
    logic                      inv, inv_n, bcd_invalid;
    logic [CNT_W-1:0]          cnt, cnt_n;
    logic [OUTPUT_WIDTH-1:0]   binary_n;
    logic                      done_n, error_n, busy_n;
    logic [3:0]                nib, in_nib;

    // Shift right one bit, then pull every BCD digit >= 8 back down by 3
    always_comb begin
        nib      = '0;
        sr_shift = sr >> 1;
        for (int i = 0; i < int'(DECIMAL_DIGITS); i++) begin
            nib = sr_shift[OUTPUT_WIDTH + 4*i +: 4];
            if (nib >= 4'd8) begin
                sr_shift[OUTPUT_WIDTH + 4*i +: 4] = nib - 4'd3;
            end
        end
    end

    // Any input digit above 9 poisons the result
    always_comb begin
        in_nib      = '0;
        bcd_invalid = 1'b0;
        for (int i = 0; i < int'(DECIMAL_DIGITS); i++) begin
            in_nib = BCD[4*i +: 4];
            if (in_nib > 4'd9) begin
                bcd_invalid = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_n  = state;
        sr_n     = sr;
        inv_n    = inv;
        cnt_n    = cnt;
        binary_n = BINARY;
        error_n  = ERROR;
        busy_n   = BUSY;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    sr_n    = {BCD, {OUTPUT_WIDTH{1'b0}}};
                    inv_n   = bcd_invalid;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                sr_n  = sr_shift;
                cnt_n = cnt + CNT_W'(1);
                if (cnt == LAST_CNT) begin
                    state_n = FINISH;
                end
            end
            FINISH: begin
                // Leftover BCD residue means the value did not fit in OUTPUT_WIDTH bits
                error_n  = inv | (|sr[SR_W-1:OUTPUT_WIDTH]);
                binary_n = error_n ? '0 : sr[OUTPUT_WIDTH-1:0];
                done_n   = 1'b1;
                busy_n   = 1'b0;
                state_n  = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            sr     <= '0;
            inv    <= 1'b0;
            cnt    <= '0;
            BINARY <= '0;
            DONE   <= 1'b0;
            ERROR  <= 1'b0;
            BUSY   <= 1'b0;
        end else begin
            state  <= state_n;
            sr     <= sr_n;
            inv    <= inv_n;
            cnt    <= cnt_n;
            BINARY <= binary_n;
            DONE   <= done_n;
            ERROR  <= error_n;
            BUSY   <= busy_n;
        end
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed bench for bcd_to_binary: default 8-digit/32-bit instance plus a 4-digit/8-bit instance.
module tb_bcd_to_binary;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] bcd;
    logic        start;
    logic [31:0] binary;
    logic        done, error, busy;

    logic [15:0] s_bcd;
    logic        s_start;
    logic [7:0]  s_binary;
    logic        s_done, s_error, s_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_to_binary dut (
        .clk    (clk),
        .resetn (resetn),
        .BCD    (bcd),
        .START  (start),
        .BINARY (binary),
        .DONE   (done),
        .ERROR  (error),
        .BUSY   (busy)
    );

    bcd_to_binary #(.DECIMAL_DIGITS(4), .OUTPUT_WIDTH(8)) dut_small (
        .clk    (clk),
        .resetn (resetn),
        .BCD    (s_bcd),
        .START  (s_start),
        .BINARY (s_binary),
        .DONE   (s_done),
        .ERROR  (s_error),
        .BUSY   (s_busy)
    );

    // Directed vectors: BCD in, expected binary, expected error
    logic [31:0] vec_bcd [5] = '{32'h12345678, 32'h99999999, 32'h00000000, 32'h000000A0, 32'h00000042};
    logic [31:0] vec_bin [5] = '{32'h00BC614E, 32'h05F5E0FF, 32'h00000000, 32'h00000000, 32'h0000002A};
    logic        vec_err [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // One START pulse on the big instance; lat = edges after the START edge until DONE is seen
    task automatic run_conv(input logic [31:0] v, output logic [31:0] bin, output logic err,
                            output int lat, output logic busy0);
        @(negedge clk);
        bcd   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy0 = busy;
        lat   = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        bin = binary;
        err = error;
    endtask

    task automatic test_reset;
        resetn  = 1'b0;
        start   = 1'b0;
        bcd     = '0;
        s_start = 1'b0;
        s_bcd   = '0;
        #12;
        n_checks++;
        if (binary !== 32'h0) begin n_fail++; $display("FAIL reset_binary: got %h want 0", binary); end
        n_checks++;
        if ({done, error, busy} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got done/err/busy=%b want 000", {done, error, busy});
        end
        n_checks++;
        if ({s_binary, s_done, s_error, s_busy} !== 11'h0) begin
            n_fail++; $display("FAIL reset_small: got %h want 0", {s_binary, s_done, s_error, s_busy});
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors;
        logic [31:0] bin, held;
        logic        err, busy0;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            run_conv(vec_bcd[i], bin, err, lat, busy0);
            n_checks++;
            if (lat !== 33) begin n_fail++; $display("FAIL latency[%0d]: got %0d want 33", i, lat); end
            n_checks++;
            if (bin !== vec_bin[i]) begin
                n_fail++; $display("FAIL binary[%0d]: bcd %h got %h want %h", i, vec_bcd[i], bin, vec_bin[i]);
            end
            n_checks++;
            if (err !== vec_err[i]) begin n_fail++; $display("FAIL error[%0d]: got %b want %b", i, err, vec_err[i]); end
            n_checks++;
            if (busy0 !== 1'b1) begin n_fail++; $display("FAIL busy_after_start[%0d]: got %b want 1", i, busy0); end
            held = binary;
            repeat (3) @(negedge clk);
            n_checks++;
            if ({binary, done, busy} !== {vec_bin[i], 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL hold[%0d]: got bin=%h done=%b busy=%b want bin=%h done=0 busy=0",
                                   i, binary, done, busy, vec_bin[i]);
            end
        end
    endtask

    task automatic test_small;
        logic [15:0] vin  [2] = '{16'h0255, 16'h0256};
        logic [7:0]  vout [2] = '{8'hFF, 8'h00};
        logic        verr [2] = '{1'b0, 1'b1};
        int          lat;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            s_bcd   = vin[i];
            s_start = 1'b1;
            @(negedge clk);
            s_start = 1'b0;
            lat     = 0;
            while (!s_done && lat < 50) begin
                @(negedge clk);
                lat++;
            end
            n_checks++;
            if (lat !== 9) begin n_fail++; $display("FAIL small_latency[%0d]: got %0d want 9", i, lat); end
            n_checks++;
            if ({s_binary, s_error} !== {vout[i], verr[i]}) begin
                n_fail++; $display("FAIL small_result[%0d]: got bin=%h err=%b want bin=%h err=%b",
                                   i, s_binary, s_error, vout[i], verr[i]);
            end
        end
    endtask

    task automatic test_ignore_start;
        int          dones = 0;
        logic [31:0] bin   = '0;
        logic        err   = 1'b1;
        @(negedge clk);
        bcd   = 32'h12345678;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bcd   = 32'h99999999;
        for (int c = 1; c <= 60; c++) begin
            start = (c == 5 || c == 20);
            @(negedge clk);
            if (done) begin
                dones++;
                bin = binary;
                err = error;
            end
        end
        start = 1'b0;
        n_checks++;
        if (dones !== 1) begin n_fail++; $display("FAIL ignore_start_dones: got %0d want 1", dones); end
        n_checks++;
        if ({bin, err} !== {32'h00BC614E, 1'b0}) begin
            n_fail++; $display("FAIL ignore_start_result: got %h err=%b want 00bc614e err=0", bin, err);
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_start_queued: busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int t1 = -1, t2 = -1, c = 0, dones = 0;
        @(negedge clk);
        bcd   = 32'h00000042;
        start = 1'b1;
        while (dones < 2 && c < 200) begin
            @(negedge clk);
            c++;
            if (done) begin
                dones++;
                if (dones == 1) t1 = c;
                else begin
                    t2    = c;
                    start = 1'b0;
                end
                n_checks++;
                if (binary !== 32'h2A) begin n_fail++; $display("FAIL b2b_binary: got %h want 0000002a", binary); end
            end
        end
        start = 1'b0;
        n_checks++;
        if (dones !== 2) begin n_fail++; $display("FAIL b2b_dones: got %0d want 2", dones); end
        n_checks++;
        if (t2 - t1 !== 34) begin n_fail++; $display("FAIL b2b_period: got %0d want 34", t2 - t1); end
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_reset_abort;
        logic [31:0] bin;
        logic        err, busy0;
        int          lat, dones = 0;
        run_conv(32'h000000A0, bin, err, lat, busy0);
        @(negedge clk);
        bcd   = 32'h00000042;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, error, binary} !== 35'h0) begin
            n_fail++; $display("FAIL async_reset: got busy=%b done=%b err=%b bin=%h want all 0",
                               busy, done, error, binary);
        end
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        n_checks++;
        if (dones !== 0) begin n_fail++; $display("FAIL reset_no_done: got %0d dones want 0", dones); end
        run_conv(32'h00000042, bin, err, lat, busy0);
        n_checks++;
        if ({bin, err, lat} !== {32'h2A, 1'b0, 33}) begin
            n_fail++; $display("FAIL post_reset_conv: got bin=%h err=%b lat=%0d want 2a 0 33", bin, err, lat);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_small();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
